// File: rtl/capture_timer_bank_if.sv
// Read port of the capture timer bank: request/select toward the bank, registered response back.
interface capture_timer_bank_if #(
    parameter int SEL_W = 4,
    parameter int CNT_W = 16
);
    logic             rd_req;
    logic [SEL_W-1:0] rd_sel;
    logic             rd_valid;
    logic [CNT_W-1:0] rd_data;
    logic             rd_ovf;
    logic             rd_done;
    logic             rd_err;

    modport master (
        output rd_req, rd_sel,
        input  rd_valid, rd_data, rd_ovf, rd_done, rd_err
    );

    modport slave (
        input  rd_req, rd_sel,
        output rd_valid, rd_data, rd_ovf, rd_done, rd_err
    );
endinterface

// File: rtl/capture_timer_bank.sv
// Per-channel start/capture interval timers with a registered single-request read port.
// Optional interrupt pulse on DONE entry, enabled by defining CAPTURE_TIMER_BANK_IRQ_EN.
module capture_timer_bank #(
    parameter int NB_CAPTURES = 10,
    parameter int CNT_W       = 16,
    parameter int SEL_W       = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_an_i,
    input  logic                   rst_i,
    input  logic [NB_CAPTURES-1:0] start_pulse_i,
    input  logic [NB_CAPTURES-1:0] capture_pulse_i,
    input  logic [NB_CAPTURES-1:0] rst_capture_pulse_i,
    output logic [NB_CAPTURES-1:0] busy_o,
    output logic [NB_CAPTURES-1:0] done_o,
    capture_timer_bank_if.slave    rd_if,
    output logic                   irq_o
);
    localparam logic [1:0]       ST_IDLE = 2'd0;
    localparam logic [1:0]       ST_RUN  = 2'd1;
    localparam logic [1:0]       ST_DONE = 2'd2;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [SEL_W:0]   NB_LIM  = (SEL_W+1)'(NB_CAPTURES);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? CNT_MAX : (v + CNT_ONE);
    endfunction

    logic [1:0]       state_q [NB_CAPTURES];
    logic [1:0]       state_d [NB_CAPTURES];
    logic [CNT_W-1:0] cnt_q   [NB_CAPTURES];
    logic [CNT_W-1:0] cnt_d   [NB_CAPTURES];
    logic [CNT_W-1:0] cap_q   [NB_CAPTURES];
    logic [CNT_W-1:0] cap_d   [NB_CAPTURES];
    logic [NB_CAPTURES-1:0] ovf_q, ovf_d;
    logic [NB_CAPTURES-1:0] busy_q, busy_d, done_q, done_d;

    logic             rd_valid_q, rd_ovf_q, rd_done_q, rd_err_q;
    logic [CNT_W-1:0] rd_data_q;
    logic [CNT_W-1:0] rd_cap_s;
    logic             rd_ovf_s, rd_done_s, rd_in_range_s;

    // Channel next-state: rst_capture beats capture beats start.
    always_comb begin
        for (int i = 0; i < NB_CAPTURES; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            cap_d[i]   = cap_q[i];
            ovf_d[i]   = ovf_q[i];
            if (rst_capture_pulse_i[i]) begin
                state_d[i] = ST_IDLE;
                cnt_d[i]   = '0;
                cap_d[i]   = '0;
                ovf_d[i]   = 1'b0;
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (start_pulse_i[i]) begin
                            state_d[i] = ST_RUN;
                            cnt_d[i]   = '0;
                            ovf_d[i]   = 1'b0;
                        end else begin
                            state_d[i] = ST_IDLE;
                        end
                    end
                    ST_RUN: begin
                        cnt_d[i] = sat_inc(cnt_q[i]);
                        // An increment that would wrap marks the channel as overflowed.
                        if (cnt_q[i] == CNT_MAX) begin
                            ovf_d[i] = 1'b1;
                        end else begin
                            ovf_d[i] = ovf_q[i];
                        end
                        if (capture_pulse_i[i]) begin
                            cap_d[i]   = sat_inc(cnt_q[i]);
                            state_d[i] = ST_DONE;
                        end else begin
                            state_d[i] = ST_RUN;
                        end
                    end
                    ST_DONE: begin
                        state_d[i] = ST_DONE;
                    end
                    default: begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                        cap_d[i]   = '0;
                        ovf_d[i]   = 1'b0;
                    end
                endcase
            end
            busy_d[i] = (state_d[i] == ST_RUN);
            done_d[i] = (state_d[i] == ST_DONE);
        end
    end

    // Channel state registers with async and synchronous clear.
    always_ff @(posedge clk_i or negedge rst_an_i) begin
        if (!rst_an_i) begin
            for (int i = 0; i < NB_CAPTURES; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
                cap_q[i]   <= '0;
            end
            ovf_q  <= '0;
            busy_q <= '0;
            done_q <= '0;
        end else if (rst_i) begin
            for (int i = 0; i < NB_CAPTURES; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
                cap_q[i]   <= '0;
            end
            ovf_q  <= '0;
            busy_q <= '0;
            done_q <= '0;
        end else begin
            for (int i = 0; i < NB_CAPTURES; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                cap_q[i]   <= cap_d[i];
            end
            ovf_q  <= ovf_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // Read select mux, built as an AND-OR so an out-of-range index selects nothing.
    always_comb begin
        rd_cap_s  = '0;
        rd_ovf_s  = 1'b0;
        rd_done_s = 1'b0;
        for (int i = 0; i < NB_CAPTURES; i++) begin
            rd_cap_s  = rd_cap_s  | ({CNT_W{rd_if.rd_sel == SEL_W'(i)}} & cap_q[i]);
            rd_ovf_s  = rd_ovf_s  | ((rd_if.rd_sel == SEL_W'(i)) & ovf_q[i]);
            rd_done_s = rd_done_s | ((rd_if.rd_sel == SEL_W'(i)) & done_q[i]);
        end
        rd_in_range_s = ({1'b0, rd_if.rd_sel} < NB_LIM);
    end

    // Registered read response; data holds between requests.
    always_ff @(posedge clk_i or negedge rst_an_i) begin
        if (!rst_an_i) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_ovf_q   <= 1'b0;
            rd_done_q  <= 1'b0;
            rd_err_q   <= 1'b0;
        end else if (rst_i) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_ovf_q   <= 1'b0;
            rd_done_q  <= 1'b0;
            rd_err_q   <= 1'b0;
        end else if (rd_if.rd_req) begin
            rd_valid_q <= 1'b1;
            rd_data_q  <= rd_in_range_s ? rd_cap_s : '0;
            rd_ovf_q   <= rd_in_range_s & rd_ovf_s;
            rd_done_q  <= rd_in_range_s & rd_done_s;
            rd_err_q   <= ~rd_in_range_s;
        end else begin
            rd_valid_q <= 1'b0;
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign rd_if.rd_valid = rd_valid_q;
    assign rd_if.rd_data  = rd_data_q;
    assign rd_if.rd_ovf   = rd_ovf_q;
    assign rd_if.rd_done  = rd_done_q;
    assign rd_if.rd_err   = rd_err_q;

`ifdef CAPTURE_TIMER_BANK_IRQ_EN
    logic irq_q;

    // One pulse per cycle in which at least one channel newly enters DONE.
    always_ff @(posedge clk_i or negedge rst_an_i) begin
        if (!rst_an_i) begin
            irq_q <= 1'b0;
        end else if (rst_i) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(done_d & ~done_q);
        end
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif
endmodule

// File: tb/tb_capture_timer_bank.sv
// Directed bench for capture_timer_bank: stimulus pushes expected read responses, a forked monitor checks them.
module tb_capture_timer_bank;
    localparam int NB = 10;
    localparam int CW = 8;
    localparam int SW = 4;
`ifdef CAPTURE_TIMER_BANK_IRQ_EN
    localparam int IRQ_EXP = 1;
`else
    localparam int IRQ_EXP = 0;
`endif

    typedef struct packed {
        logic [CW-1:0] data;
        logic          ovf;
        logic          done;
        logic          err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_an;
    logic          rst;
    logic [NB-1:0] start, capture, rcap;
    logic [NB-1:0] busy, done;
    logic          irq;
    exp_t          exp_q[$];
    exp_t          mon_e;
    int            n_total = 0;
    int            n_pass  = 0;
    int            irq_cnt = 0;
    int            irq_base;

    capture_timer_bank_if #(.SEL_W(SW), .CNT_W(CW)) rd_if ();

    capture_timer_bank #(.NB_CAPTURES(NB), .CNT_W(CW), .SEL_W(SW)) dut (
        .clk_i               (clk),
        .rst_an_i            (rst_an),
        .rst_i               (rst),
        .start_pulse_i       (start),
        .capture_pulse_i     (capture),
        .rst_capture_pulse_i (rcap),
        .busy_o              (busy),
        .done_o              (done),
        .rd_if               (rd_if),
        .irq_o               (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [NB-1:0] s, input logic [NB-1:0] c, input logic [NB-1:0] r);
        start = s; capture = c; rcap = r;
        tick();
        start = '0; capture = '0; rcap = '0;
    endtask

    task automatic rd(input int sel, input logic [CW-1:0] d, input logic o, input logic dn, input logic er);
        exp_q.push_back({d, o, dn, er});
        rd_if.rd_req = 1'b1;
        rd_if.rd_sel = sel[SW-1:0];
        tick();
        rd_if.rd_req = 1'b0;
    endtask

    function automatic logic [NB-1:0] ch(input int i);
        return NB'(1) << i;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_an = 1'b0; rst = 1'b0;
        start = '0; capture = '0; rcap = '0;
        rd_if.rd_req = 1'b0; rd_if.rd_sel = '0;

        fork
            forever begin
                @(negedge clk);
                if (irq === 1'b1) irq_cnt++;
                if (rd_if.rd_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        chk("rd_unexpected_valid", 32'(1), 32'(0));
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("rd_data", 32'(rd_if.rd_data), 32'(mon_e.data));
                        chk("rd_ovf",  32'(rd_if.rd_ovf),  32'(mon_e.ovf));
                        chk("rd_done", 32'(rd_if.rd_done), 32'(mon_e.done));
                        chk("rd_err",  32'(rd_if.rd_err),  32'(mon_e.err));
                    end
                end
            end
        join_none

        // Reset state
        #12;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_valid", 32'(rd_if.rd_valid), 32'(0));
        chk("rst_data", 32'(rd_if.rd_data), 32'(0));
        chk("rst_irq", 32'(irq), 32'(0));
        @(negedge clk);
        rst_an = 1'b1;

        // Basic interval: 25 edges from start to capture
        pulse(ch(0), '0, '0);
        repeat (24) tick();
        chk("basic_busy0", 32'(busy[0]), 32'(1));
        pulse('0, ch(0), '0);
        chk("basic_done0", 32'(done[0]), 32'(1));
        chk("basic_busy0_off", 32'(busy[0]), 32'(0));
        rd(0, 8'd25, 1'b0, 1'b1, 1'b0);

        // Overflow: 300 edges saturate an 8-bit counter
        pulse(ch(3), '0, '0);
        repeat (299) tick();
        pulse('0, ch(3), '0);
        rd(3, 8'd255, 1'b1, 1'b1, 1'b0);
        pulse('0, '0, ch(3));
        chk("ovf_rearm_done3", 32'(done[3]), 32'(0));
        rd(3, 8'd0, 1'b0, 1'b0, 1'b0);

        // Priority: rst_capture wins over start; capture in IDLE ignored
        pulse(ch(1), '0, '0);
        repeat (6) tick();
        pulse('0, ch(1), '0);
        rd(1, 8'd7, 1'b0, 1'b1, 1'b0);
        pulse(ch(1), '0, ch(1));
        chk("prio_busy1", 32'(busy[1]), 32'(0));
        chk("prio_done1", 32'(done[1]), 32'(0));
        rd(1, 8'd0, 1'b0, 1'b0, 1'b0);
        pulse('0, ch(2), '0);
        chk("idle_cap_done2", 32'(done[2]), 32'(0));
        chk("idle_cap_busy2", 32'(busy[2]), 32'(0));

        // Parallel channels and back-to-back reads including an out-of-range select
        pulse('0, '0, ch(0));
        pulse(ch(0) | ch(9), '0, '0);
        repeat (2) tick();
        pulse('0, ch(9), '0);
        chk("par_busy0", 32'(busy[0]), 32'(1));
        repeat (11) tick();
        pulse('0, ch(0), '0);
        exp_q.push_back({8'd3, 1'b0, 1'b1, 1'b0});
        exp_q.push_back({8'd15, 1'b0, 1'b1, 1'b0});
        exp_q.push_back({8'd0, 1'b0, 1'b0, 1'b1});
        rd_if.rd_req = 1'b1;
        rd_if.rd_sel = 4'd9;  tick();
        rd_if.rd_sel = 4'd0;  tick();
        rd_if.rd_sel = 4'd12; tick();
        rd_if.rd_req = 1'b0;
        tick();
        chk("b2b_drained", 32'(exp_q.size()), 32'(0));
        chk("b2b_valid_low", 32'(rd_if.rd_valid), 32'(0));

        // Synchronous clear mid-run
        pulse(ch(4), '0, '0);
        repeat (5) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("srst_busy4", 32'(busy[4]), 32'(0));
        chk("srst_done_all", 32'(done), 32'(0));
        rd(4, 8'd0, 1'b0, 1'b0, 1'b0);
        rd(0, 8'd0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle with live state and held read data
        pulse(ch(4), '0, '0);
        repeat (3) tick();
        pulse(ch(5), ch(4), '0);
        rd(4, 8'd4, 1'b0, 1'b1, 1'b0);
        tick();
        #3 rst_an = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'(0));
        chk("arst_done", 32'(done), 32'(0));
        chk("arst_data", 32'(rd_if.rd_data), 32'(0));
        chk("arst_rd_done", 32'(rd_if.rd_done), 32'(0));
        chk("arst_irq", 32'(irq), 32'(0));
        #2 rst_an = 1'b1;
        pulse(ch(6), '0, '0);
        chk("post_arst_busy6", 32'(busy[6]), 32'(1));

        // Simultaneous DONE entry on two channels yields at most one interrupt
        pulse(ch(0) | ch(5), '0, '0);
        repeat (2) tick();
        irq_base = irq_cnt;
        pulse('0, ch(0) | ch(5), '0);
        repeat (3) tick();
        chk("irq_single", 32'(irq_cnt - irq_base), 32'(IRQ_EXP));
        rd(5, 8'd3, 1'b0, 1'b1, 1'b0);
        rd(0, 8'd3, 1'b0, 1'b1, 1'b0);
        repeat (2) tick();
        chk("final_drained", 32'(exp_q.size()), 32'(0));
`ifndef CAPTURE_TIMER_BANK_IRQ_EN
        chk("irq_never", 32'(irq_cnt), 32'(0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
